// File: rtl/alu_exec.sv
// Execute stage: single-cycle ADD/AND/NOT/SL/SR and an optional iterative shift-add MUL.
// Define ALU_EXEC_MUL_EN to build the multiplier; without it, op 0101 reports ILLEGAL.
module alu_exec #(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           alu_control,
  input  logic                 is_immediate,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  input  logic [IMM_WIDTH-1:0] imm,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [2:0]           cc,
  output logic                 illegal,
  output logic [1:0]           dbg_state
);

  // Handshake: start is sampled on a rising edge whenever busy=0 (including the
  // cycle that carries done); done is a one-cycle pulse marking result/cc/illegal
  // valid, and those outputs hold until the next done. start while busy=1 is dropped.

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_SL  = 4'b0110;
  localparam logic [3:0] OP_SR  = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0
`ifdef ALU_EXEC_MUL_EN
    ,
    S_MUL_RUN = 2'd1,
    S_MUL_FIN = 2'd2
`endif
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] single_res;
  logic             single_ill;
  logic             accept;

  function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1])   return 3'b100;
    else if (v == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  assign b_eff = is_immediate ? {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm} : src_b;

  always_comb begin
    single_res = '0;
    single_ill = 1'b0;
    case (alu_control)
      OP_ADD: single_res = src_a + b_eff;
      OP_AND: single_res = src_a & b_eff;
      OP_NOT: single_res = ~src_a;
      OP_SL:  single_res = src_a << b_eff[3:0];
      OP_SR:  single_res = src_a >> b_eff[3:0];
      default: begin
        single_res = '0;
        single_ill = 1'b1;
      end
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam int         CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [WIDTH-1:0] acc, mcand, mplier, acc_next;
  logic [CW-1:0]    iter;
  logic             is_mul;

  assign is_mul   = (alu_control == OP_MUL);
  assign accept   = start && (state != S_MUL_RUN);
  assign busy     = (state == S_MUL_RUN);
  // One multiplier bit per cycle, LSB first; the multiplicand shifts left in step.
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept && is_mul) state_next = S_MUL_RUN;
      S_MUL_RUN: if (iter == LAST_ITER) state_next = S_MUL_FIN;
      S_MUL_FIN: state_next = (accept && is_mul) ? S_MUL_RUN : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end
`else
  assign accept = start;
  assign busy   = 1'b0;

  always_comb begin
    state_next = S_IDLE;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      result  <= '0;
      cc      <= 3'b010;
      illegal <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      iter    <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      if (accept && is_mul) begin
        acc    <= '0;
        mcand  <= src_a;
        mplier <= b_eff;
        iter   <= '0;
      end else if (accept) begin
        done    <= 1'b1;
        result  <= single_res;
        cc      <= cc_of(single_res);
        illegal <= single_ill;
      end else if (state == S_MUL_RUN) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        iter   <= iter + 1'b1;
        if (iter == LAST_ITER) begin
          done    <= 1'b1;
          result  <= acc_next;
          cc      <= cc_of(acc_next);
          illegal <= 1'b0;
        end
      end
`else
      if (accept) begin
        done    <= 1'b1;
        result  <= single_res;
        cc      <= cc_of(single_res);
        illegal <= single_ill;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed literal cases followed by random traffic, all checked
// every cycle against a cycle-count/arithmetic model and a done-result queue.
module tb_alu_exec;
  localparam int W  = 16;
  localparam int IW = 5;
`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    alu_control = '0;
  logic          is_immediate = 1'b0;
  logic [W-1:0]  src_a = '0, src_b = '0;
  logic [IW-1:0] imm = '0;
  logic          busy, done, illegal;
  logic [W-1:0]  result;
  logic [2:0]    cc;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  alu_exec #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_control(alu_control),
    .is_immediate(is_immediate), .src_a(src_a), .src_b(src_b), .imm(imm),
    .busy(busy), .done(done), .result(result), .cc(cc), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W+3:0] exp_q[$];     // {illegal, cc, result} for every predicted done
  logic          m_busy, m_done, m_ill, model_on = 1'b0;
  logic [W-1:0]  m_result, mul_pend;
  logic [2:0]    m_cc;
  int            mul_left;

  function automatic logic [2:0] ref_cc(input logic [W-1:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 0)         return 3'b010;
    return 3'b001;
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] b, r;
    logic         ill;
    if (reset) begin
      m_busy = 0; m_done = 0; m_result = '0; m_cc = 3'b010; m_ill = 0;
      mul_left = 0; exp_q.delete(); model_on = 1'b1;
    end else begin
      m_done = 0;
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          m_done = 1; m_result = mul_pend; m_cc = ref_cc(mul_pend); m_ill = 0;
          exp_q.push_back({m_ill, m_cc, m_result});
        end
      end else if (start) begin
        b = is_immediate ? W'($signed(imm)) : src_b;
        ill = 0;
        r = '0;
        case (alu_control)
          4'd0: r = src_a + b;
          4'd1: r = src_a & b;
          4'd4: r = ~src_a;
          4'd6: r = src_a << (b % 16);
          4'd7: r = src_a >> (b % 16);
          default: ill = 1;
        endcase
        if (alu_control == 4'd5 && MUL_EN) begin
          mul_left = W;
          mul_pend = W'(src_a * b);
        end else begin
          m_done = 1; m_result = r; m_cc = ref_cc(r); m_ill = ill;
          exp_q.push_back({m_ill, m_cc, m_result});
        end
      end
      m_busy = (mul_left > 0);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [W+3:0] e;
    if (model_on) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("result", result, m_result);
      check("cc", cc, m_cc);
      check("illegal", illegal, m_ill);
      check("cc_onehot", $countones(cc), 1);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_done: got done=1 expected no pending result at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_entry", {illegal, cc, result}, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic imm_sel, input logic [IW-1:0] iv);
    @(negedge clk);
    alu_control = op; src_a = a; src_b = b; is_immediate = imm_sel; imm = iv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_a = W'($urandom); src_b = W'($urandom); imm = IW'($urandom);
  endtask

  initial begin
    int done_cnt;
    logic [3:0] ops[8] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd2, 4'd15};
    repeat (3) @(negedge clk);
    check("rst_result", result, 16'h0000);
    check("rst_cc", cc, 3'b010);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    reset = 1'b0;

    do_op(4'd0, 16'h0005, 16'h0000, 1'b1, 5'b11110);
    check("add_done", done, 1'b1);
    check("add_result", result, 16'h0003);
    check("add_cc", cc, 3'b001);

    do_op(4'd1, 16'hF0F0, 16'h0FF0, 1'b0, 5'd0);
    check("and_result", result, 16'h00F0);
    check("and_cc", cc, 3'b001);
    do_op(4'd4, 16'h0000, 16'h1234, 1'b0, 5'd0);
    check("not_result", result, 16'hFFFF);
    check("not_cc", cc, 3'b100);

    do_op(4'd6, 16'h8001, 16'h0000, 1'b1, 5'd1);
    check("sl_result", result, 16'h0002);
    do_op(4'd7, 16'h8000, 16'd15, 1'b0, 5'd0);
    check("sr15_result", result, 16'h0001);
    do_op(4'd7, 16'h1234, 16'h0000, 1'b0, 5'd0);
    check("sr0_result", result, 16'h1234);
    do_op(4'd15, 16'h1234, 16'h5678, 1'b0, 5'd0);
    check("ill_flag", illegal, 1'b1);
    check("ill_result", result, 16'h0000);
    check("ill_cc", cc, 3'b010);
    do_op(4'd0, 16'h0001, 16'h0001, 1'b0, 5'd0);
    check("ill_cleared", illegal, 1'b0);
    check("add2_result", result, 16'h0002);

`ifdef ALU_EXEC_MUL_EN
    do_op(4'd5, 16'h0003, 16'hFFFE, 1'b0, 5'd0);
    for (int i = 1; i <= W; i++) begin
      check("mul_busy", busy, 1'b1);
      check("mul_no_done", done, 1'b0);
      if (i == 5) begin start = 1'b1; alu_control = 4'd0; end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
    check("mul_done", done, 1'b1);
    check("mul_busy_low", busy, 1'b0);
    check("mul_result", result, 16'hFFFA);
    check("mul_cc", cc, 3'b100);
    @(negedge clk);
    check("mul_ignored_start", result, 16'hFFFA);
    check("mul_no_extra_done", done, 1'b0);

    do_op(4'd5, 16'h1234, 16'h0101, 1'b0, 5'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmul_busy", busy, 1'b0);
    check("rstmul_done", done, 1'b0);
    check("rstmul_result", result, 16'h0000);
    check("rstmul_cc", cc, 3'b010);
    done_cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("rstmul_no_later_done", done_cnt, 0);
`else
    do_op(4'd5, 16'h0003, 16'hFFFE, 1'b0, 5'd0);
    check("mul_off_done", done, 1'b1);
    check("mul_off_illegal", illegal, 1'b1);
    check("mul_off_busy", busy, 1'b0);
    check("mul_off_result", result, 16'h0000);
`endif

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start        = ($urandom_range(0, 2) == 0);
      alu_control  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
      is_immediate = $urandom_range(0, 1);
      imm          = IW'($urandom);
      case ($urandom_range(0, 5))
        0:       src_a = '0;
        1:       src_a = 16'h8000;
        2:       src_a = 16'hFFFF;
        default: src_a = W'($urandom);
      endcase
      src_b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 17)) : W'($urandom);
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
